// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: work_type encodings, IO window base, FSM codes.
// Latency: none (types, constants and a pure load-extension function).
// Backpressure: none.
package mem_arbiter_pkg;

  localparam logic [1:0]  WT_BYTE         = 2'b00;
  localparam logic [1:0]  WT_HALF         = 2'b01;
  localparam logic [1:0]  WT_WORD         = 2'b10;
  localparam int          WT_UNSIGNED     = 2;        // bit index of the unsigned flag
  localparam logic [2:0]  IF_TYPE         = 3'b010;   // fetches are always signed words
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Controller returns load data LSB-aligned; widen it to 32 bits per work_type.
  function automatic logic [31:0] load_extend(input logic [2:0] wt, input logic [31:0] raw);
    logic sgn;
    sgn         = 1'b0;
    load_extend = raw;
    case (wt[1:0])
      WT_BYTE: begin
        sgn         = raw[7] & ~wt[WT_UNSIGNED];
        load_extend = {{24{sgn}}, raw[7:0]};
      end
      WT_HALF: begin
        sgn         = raw[15] & ~wt[WT_UNSIGNED];
        load_extend = {{16{sgn}}, raw[15:0]};
      end
      default: load_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto the byte-serial memory controller.
// Latency: grant in IDLE (cycle 0), new_task in cycle 1, done pulse one cycle after controller completion.
// Backpressure: requesters hold req until done; IO stores stall while the UART buffer is full; rdy_in low freezes all.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
  parameter bit          LS_FIRST = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_is_write,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_type,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        mc_new_task,
  output logic        mc_is_write,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [2:0]  mc_type,
  input  logic [31:0] mc_rdata,
  input  logic        mc_ready,
  input  logic        mc_is_working
);

  arb_state_t  state, state_nxt;
  owner_t      owner, owner_nxt;
  logic        prio_ls, prio_ls_nxt;
  logic        new_task_nxt, is_write_nxt;
  logic [31:0] addr_nxt, wdata_nxt;
  logic [2:0]  type_nxt;
  logic        if_done_nxt, ls_done_nxt;
  logic [31:0] if_rdata_nxt, ls_rdata_nxt;
  logic        ls_io_block, if_cand, ls_cand, grant_ls, flush_read;

  // A requester still holds req during its own done cycle, so it is masked then to avoid a re-grant.
  assign ls_io_block = ls_is_write && (ls_addr >= IO_BASE) && io_buffer_full;
  assign if_cand     = if_req && !if_done;
  assign ls_cand     = ls_req && !ls_done && !ls_io_block;
  assign grant_ls    = ls_cand && (!if_cand || prio_ls);
  // Stores are never abandoned once issued; only in-flight reads are dropped by a flush.
  assign flush_read  = rob_clear && !mc_is_write;

  // State register and all registered outputs; rdy_in low holds everything, including done pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= ARB_IDLE;
      owner       <= OWN_IF;
      prio_ls     <= LS_FIRST;
      mc_new_task <= 1'b0;
      mc_is_write <= 1'b0;
      mc_addr     <= 32'h0;
      mc_wdata    <= 32'h0;
      mc_type     <= 3'b000;
      if_done     <= 1'b0;
      if_rdata    <= 32'h0;
      ls_done     <= 1'b0;
      ls_rdata    <= 32'h0;
    end else if (rdy_in) begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      prio_ls     <= prio_ls_nxt;
      mc_new_task <= new_task_nxt;
      mc_is_write <= is_write_nxt;
      mc_addr     <= addr_nxt;
      mc_wdata    <= wdata_nxt;
      mc_type     <= type_nxt;
      if_done     <= if_done_nxt;
      if_rdata    <= if_rdata_nxt;
      ls_done     <= ls_done_nxt;
      ls_rdata    <= ls_rdata_nxt;
    end
  end

  // Next-state and next-output logic: grant in IDLE, one-cycle issue, completion detect in WAIT.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    prio_ls_nxt  = prio_ls;
    new_task_nxt = 1'b0;
    is_write_nxt = mc_is_write;
    addr_nxt     = mc_addr;
    wdata_nxt    = mc_wdata;
    type_nxt     = mc_type;
    if_done_nxt  = 1'b0;
    ls_done_nxt  = 1'b0;
    if_rdata_nxt = if_rdata;
    ls_rdata_nxt = ls_rdata;
    case (state)
      ARB_IDLE: begin
        if (!rob_clear && (if_cand || ls_cand)) begin
          state_nxt    = ARB_ISSUE;
          new_task_nxt = 1'b1;
          if (if_cand && ls_cand) prio_ls_nxt = !prio_ls;
          if (grant_ls) begin
            owner_nxt    = OWN_LS;
            is_write_nxt = ls_is_write;
            addr_nxt     = ls_addr;
            wdata_nxt    = ls_wdata;
            type_nxt     = ls_type;
          end else begin
            owner_nxt    = OWN_IF;
            is_write_nxt = 1'b0;
            addr_nxt     = if_addr;
            wdata_nxt    = 32'h0;
            type_nxt     = IF_TYPE;
          end
        end
      end
      // The controller has not yet seen new_task here, so its status lines are meaningless.
      ARB_ISSUE: begin
        state_nxt = flush_read ? ARB_IDLE : ARB_WAIT;
      end
      ARB_WAIT: begin
        if (flush_read) begin
          state_nxt = ARB_IDLE;
        end else if (!mc_is_write && mc_ready) begin
          state_nxt = ARB_IDLE;
          if (owner == OWN_LS) begin
            ls_done_nxt  = 1'b1;
            ls_rdata_nxt = load_extend(mc_type, mc_rdata);
          end else begin
            if_done_nxt  = 1'b1;
            if_rdata_nxt = mc_rdata;
          end
        end else if (mc_is_write && !mc_is_working) begin
          state_nxt   = ARB_IDLE;
          ls_done_nxt = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-serial controller and byte memory.
// Latency: controller busy 1/2/4 cycles per byte/half/word after seeing new_task.
// Backpressure: requests held until done; controller freezes with rdy_in like the arbiter.
module tb_mem_arbiter;

  logic        clk_in;
  logic        rst_in, rdy_in, rob_clear, io_buffer_full;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_is_write, ls_done;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_type;
  logic        mc_new_task, mc_is_write, mc_ready, mc_is_working;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;
  logic [2:0]  mc_type;

  mem_arbiter #(.IO_BASE(32'h0003_0000), .LS_FIRST(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_is_write(ls_is_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_type(ls_type), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mc_new_task(mc_new_task), .mc_is_write(mc_is_write), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_type(mc_type), .mc_rdata(mc_rdata), .mc_ready(mc_ready),
    .mc_is_working(mc_is_working)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- controller + memory model ----------------
  int          cnt;
  logic        m_write;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_type;
  logic [7:0]  mem [0:1023];
  logic [9:0]  a0;
  logic [31:0] rd_raw;

  assign a0            = m_addr[9:0];
  assign mc_is_working = (cnt > 1);
  assign mc_ready      = (cnt == 1) && !m_write;
  assign mc_rdata      = mc_ready ? rd_raw : 32'hDEAD_DEAD;

  always_comb begin
    case (m_type[1:0])
      2'b00:   rd_raw = {24'h0, mem[a0]};
      2'b01:   rd_raw = {16'h0, mem[a0 + 10'd1], mem[a0]};
      default: rd_raw = {mem[a0 + 10'd3], mem[a0 + 10'd2], mem[a0 + 10'd1], mem[a0]};
    endcase
  end

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= 0; m_write <= 1'b0; m_addr <= 32'h0; m_wdata <= 32'h0; m_type <= 3'b0;
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h100] <= 8'h78; mem[10'h101] <= 8'h56; mem[10'h102] <= 8'h34; mem[10'h103] <= 8'h12;
      mem[10'h104] <= 8'h80; mem[10'h106] <= 8'h34; mem[10'h107] <= 8'hF2;
      mem[10'h201] <= 8'h11; mem[10'h202] <= 8'h22; mem[10'h203] <= 8'h33;
      mem[10'h20A] <= 8'hAA; mem[10'h20B] <= 8'hBB;
    end else if (rdy_in) begin
      if (mc_new_task) begin
        cnt     <= mc_type[1] ? 4 : (mc_type[0] ? 2 : 1);
        m_write <= mc_is_write; m_addr <= mc_addr; m_wdata <= mc_wdata; m_type <= mc_type;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1 && m_write && m_addr < 32'h0003_0000) begin
          mem[a0] <= m_wdata[7:0];
          if (m_type[1:0] != 2'b00) mem[a0 + 10'd1] <= m_wdata[15:8];
          if (m_type[1]) begin
            mem[a0 + 10'd2] <= m_wdata[23:16];
            mem[a0 + 10'd3] <= m_wdata[31:24];
          end
        end
      end
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit use_if; logic [31:0] ia;
    bit use_ls; bit lw; logic [2:0] lt; logic [31:0] la; logic [31:0] wd;
    int full; int clr; int frz; int frzn;
    int e_iss1; logic [31:0] e_addr; logic [2:0] e_type; int e_iss2;
    int e_if; logic [31:0] e_ifrd; int e_ls; logic [31:0] e_lsrd; int e_ifhi; int e_lshi;
  } vec_t;

  localparam int MAXC = 15;
  int          r_iss1, r_iss2, r_if, r_ls, r_ifhi, r_lshi;
  logic [31:0] r_addr, r_ifrd, r_lsrd;
  logic [2:0]  r_type;

  // Drives one scenario for MAXC cycles starting at a negedge (cycle 0) and records what was seen.
  task automatic run_op(input vec_t v);
    r_iss1 = -1; r_iss2 = -1; r_if = -1; r_ls = -1; r_ifhi = 0; r_lshi = 0;
    r_addr = 32'h0; r_ifrd = 32'h0; r_lsrd = 32'h0; r_type = 3'b0;
    if_req = v.use_if; if_addr = v.ia;
    ls_req = v.use_ls; ls_is_write = v.lw; ls_addr = v.la; ls_wdata = v.wd; ls_type = v.lt;
    for (int k = 0; k < MAXC; k++) begin
      io_buffer_full = (k < v.full);
      rob_clear      = (k == v.clr);
      if (k == v.clr) begin
        if_req = 1'b0;
        if (!v.lw) ls_req = 1'b0;
      end
      rdy_in = !(k >= v.frz && k < v.frz + v.frzn);
      @(negedge clk_in);
      if (mc_new_task) begin
        if (r_iss1 < 0) begin r_iss1 = k + 1; r_addr = mc_addr; r_type = mc_type; end
        else if (r_iss2 < 0) r_iss2 = k + 1;
      end
      if (if_done) begin
        r_ifhi++;
        if (r_if < 0) begin r_if = k + 1; r_ifrd = if_rdata; if_req = 1'b0; end
      end
      if (ls_done) begin
        r_lshi++;
        if (r_ls < 0) begin r_ls = k + 1; r_lsrd = ls_rdata; ls_req = 1'b0; end
      end
    end
    io_buffer_full = 1'b0; rob_clear = 1'b0; rdy_in = 1'b1; if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic check_row(input string tag, input vec_t v);
    run_op(v);
    chk({tag, ".iss1_cycle"}, r_iss1, v.e_iss1);
    chk({tag, ".iss1_addr"}, r_addr, v.e_addr);
    chk({tag, ".iss1_type"}, {29'b0, r_type}, {29'b0, v.e_type});
    chk({tag, ".iss2_cycle"}, r_iss2, v.e_iss2);
    chk({tag, ".if_done_cycle"}, r_if, v.e_if);
    chk({tag, ".ls_done_cycle"}, r_ls, v.e_ls);
    chk({tag, ".if_done_high"}, r_ifhi, v.e_ifhi);
    chk({tag, ".ls_done_high"}, r_lshi, v.e_lshi);
    if (v.e_if >= 0) chk({tag, ".if_rdata"}, r_ifrd, v.e_ifrd);
    if (v.e_ls >= 0 && !v.lw) chk({tag, ".ls_rdata"}, r_lsrd, v.e_lsrd);
  endtask

  localparam int NV = 20;
  vec_t tbl [NV];
  vec_t post_tie, post_frz;

  initial begin
    // use_if ia | use_ls lw lt la wd | full clr frz frzn | iss1 addr type iss2 | if ifrd | ls lsrd | ifhi lshi
    tbl[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 3'b000, 32'h104, 32'h0,        0, -1, -1, 0, 1, 32'h104,   3'b000,  4,  9, 32'h12345678,  3, 32'hFFFFFF80, 1, 1};
    tbl[1]  = '{1'b1, 32'h100, 1'b1, 1'b0, 3'b101, 32'h106, 32'h0,        0, -1, -1, 0, 1, 32'h100,   3'b010,  7,  6, 32'h12345678, 10, 32'h0000F234, 1, 1};
    tbl[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0,   32'h0,        0, -1, -1, 0, 1, 32'h100,   3'b010, -1,  6, 32'h12345678, -1, 32'h0,        1, 0};
    tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b100, 32'h104, 32'h0,        0, -1, -1, 0, 1, 32'h104,   3'b100, -1, -1, 32'h0,         3, 32'h00000080, 0, 1};
    tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b001, 32'h106, 32'h0,        0, -1, -1, 0, 1, 32'h106,   3'b001, -1, -1, 32'h0,         4, 32'hFFFFF234, 0, 1};
    tbl[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        0, -1, -1, 0, 1, 32'h100,   3'b010, -1, -1, 32'h0,         6, 32'h12345678, 0, 1};
    tbl[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 3'b000, 32'h200, 32'h123456AB, 0, -1, -1, 0, 1, 32'h200,   3'b000, -1, -1, 32'h0,         3, 32'h0,        0, 1};
    tbl[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b010, 32'h200, 32'h0,        0, -1, -1, 0, 1, 32'h200,   3'b010, -1, -1, 32'h0,         6, 32'h332211AB, 0, 1};
    tbl[8]  = '{1'b1, 32'h100, 1'b1, 1'b1, 3'b010, 32'h30000, 32'h41,     5, -1, -1, 0, 1, 32'h100,   3'b010,  7,  6, 32'h12345678, 12, 32'h0,        1, 1};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 3'b010, 32'h30004, 32'h42,     5, -1, -1, 0, 6, 32'h30004, 3'b010, -1, -1, 32'h0,        11, 32'h0,        0, 1};
    tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b010, 32'h30000, 32'h0,      5, -1, -1, 0, 1, 32'h30000, 3'b010, -1, -1, 32'h0,         6, 32'h0,        0, 1};
    tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 3'b010, 32'h2FFFC, 32'h99,     5, -1, -1, 0, 1, 32'h2FFFC, 3'b010, -1, -1, 32'h0,         6, 32'h0,        0, 1};
    tbl[12] = '{1'b1, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0,   32'h0,        0,  3, -1, 0, 1, 32'h100,   3'b010, -1, -1, 32'h0,        -1, 32'h0,        0, 0};
    tbl[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        0, -1, -1, 0, 1, 32'h100,   3'b010, -1, -1, 32'h0,         6, 32'h12345678, 0, 1};
    tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b000, 32'h104, 32'h0,        0,  1, -1, 0, 1, 32'h104,   3'b000, -1, -1, 32'h0,        -1, 32'h0,        0, 0};
    tbl[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 3'b001, 32'h208, 32'h5678,     0,  2, -1, 0, 1, 32'h208,   3'b001, -1, -1, 32'h0,         4, 32'h0,        0, 1};
    tbl[16] = '{1'b0, 32'h0,   1'b1, 1'b0, 3'b010, 32'h208, 32'h0,        0, -1, -1, 0, 1, 32'h208,   3'b010, -1, -1, 32'h0,         6, 32'hBBAA5678, 0, 1};
    tbl[17] = '{1'b0, 32'h0,   1'b1, 1'b1, 3'b000, 32'h20C, 32'h5A,       0,  0, -1, 0, 2, 32'h20C,   3'b000, -1, -1, 32'h0,         4, 32'h0,        0, 1};
    tbl[18] = '{1'b1, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0,   32'h0,        0, -1,  6, 2, 1, 32'h100,   3'b010, -1,  6, 32'h12345678, -1, 32'h0,        3, 0};
    tbl[19] = '{1'b1, 32'h100, 1'b1, 1'b0, 3'b100, 32'h104, 32'h0,        0, -1, -1, 0, 1, 32'h104,   3'b100,  4,  9, 32'h12345678,  3, 32'h00000080, 1, 1};
    post_tie = tbl[19];
    post_frz = '{1'b1, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, -1, 2, 3, 1, 32'h100, 3'b010, -1, 9, 32'h12345678, -1, 32'h0, 1, 0};

    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_is_write = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_type = 3'b0;
    repeat (2) @(negedge clk_in);
    chk("reset.flags", {28'b0, if_done, ls_done, mc_new_task, mc_is_write}, 32'h0);
    chk("reset.mc_addr", mc_addr, 32'h0);
    chk("reset.mc_wdata_type", mc_wdata | {29'b0, mc_type}, 32'h0);
    chk("reset.rdata", if_rdata | ls_rdata, 32'h0);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("idle.no_task", {31'b0, mc_new_task}, 32'h0);

    for (int i = 0; i < NV; i++) check_row($sformatf("row%0d", i), tbl[i]);

    // Asynchronous reset in the middle of a word fetch clears every output immediately.
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) @(negedge clk_in);
    chk("midwait.mc_addr", mc_addr, 32'h100);
    #2 rst_in = 1'b0;
    #1;
    chk("arst.flags", {28'b0, if_done, ls_done, mc_new_task, mc_is_write}, 32'h0);
    chk("arst.mc_addr", mc_addr, 32'h0);
    chk("arst.mc_type", {29'b0, mc_type}, 32'h0);
    chk("arst.if_rdata", if_rdata, 32'h0);
    chk("arst.ls_rdata", ls_rdata, 32'h0);
    if_req = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("arst.idle_after_release", {31'b0, mc_new_task}, 32'h0);

    // Priority was left favouring IF; reset must restore LS-first.
    check_row("post_reset_tie", post_tie);
    // rdy_in low for three cycles mid-WAIT stretches the fetch by exactly three cycles.
    check_row("post_reset_freeze", post_frz);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
